// File: rtl/sdr_port_sequencer_2r1w_64.sv
// Purpose: sequences two read ports and one buffered write port onto the SDR 2r1w 64-word array.
// Latency: write/read issue one cycle after accept; read response RD_LAT cycles after issue.
// Backpressure: wr_req_ready drops when the 4-entry FIFO is full; a read port stalls while its slot waits on older writes or hold.
module sdr_port_sequencer_2r1w_64 #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              rd_req_valid_0,
  output logic              rd_req_ready_0,
  input  logic [0:5]        rd_req_adr_0,
  input  logic [TAG_W-1:0]  rd_req_tag_0,
  input  logic              rd_req_valid_1,
  output logic              rd_req_ready_1,
  input  logic [0:5]        rd_req_adr_1,
  input  logic [TAG_W-1:0]  rd_req_tag_1,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [0:5]        wr_req_adr,
  input  logic [DATA_W-1:0] wr_req_dat,
  output logic              rd_enb_0,
  output logic [0:5]        rd_adr_0,
  output logic              rd_enb_1,
  output logic [0:5]        rd_adr_1,
  output logic              wr_enb_0,
  output logic [0:5]        wr_adr_0,
  output logic [DATA_W-1:0] wr_dat_0,
  output logic              rd_rsp_valid_0,
  output logic [TAG_W-1:0]  rd_rsp_tag_0,
  output logic              rd_rsp_valid_1,
  output logic [TAG_W-1:0]  rd_rsp_tag_1
);

  typedef struct packed {
    logic [0:5]        adr;
    logic [DATA_W-1:0] dat;
  } wr_ent_t;

  // write FIFO: circular buffer, position p counts from the head
  wr_ent_t    fifo_q [4];
  logic [1:0] head_q;
  logic [1:0] tail_q;
  logic [2:0] cnt_q;
  logic       push;
  logic       pop;

  // per-port read slots, indexed by port number
  logic             rq_vld [2];
  logic [0:5]       rq_adr [2];
  logic [TAG_W-1:0] rq_tag [2];
  logic             slot_vld_q [2];
  logic [0:5]       slot_adr_q [2];
  logic [TAG_W-1:0] slot_tag_q [2];
  logic [2:0]       drain_q [2];
  logic             rd_enb [2];
  logic             rd_rdy [2];
  logic [2:0]       depth [2];

  // response pipes
  logic             pipe_vld_q [2][RD_LAT];
  logic [TAG_W-1:0] pipe_tag_q [2][RD_LAT];

  assign rq_vld[0] = rd_req_valid_0;
  assign rq_vld[1] = rd_req_valid_1;
  assign rq_adr[0] = rd_req_adr_0;
  assign rq_adr[1] = rd_req_adr_1;
  assign rq_tag[0] = rd_req_tag_0;
  assign rq_tag[1] = rd_req_tag_1;

  // ready is full-based only so it never depends on the same-cycle pop
  assign wr_req_ready = (cnt_q != 3'd4);
  assign wr_enb_0     = (cnt_q != 3'd0) & ~hold;
  assign wr_adr_0     = fifo_q[head_q].adr;
  assign wr_dat_0     = fifo_q[head_q].dat;
  assign push         = wr_req_valid & wr_req_ready;
  assign pop          = wr_enb_0;

  // FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
      head_q <= 2'd0;
      tail_q <= 2'd0;
      cnt_q  <= 3'd0;
    end else begin
      if (push) begin
        fifo_q[tail_q] <= {wr_req_adr, wr_req_dat};
        tail_q         <= tail_q + 2'd1;
      end
      if (pop) head_q <= head_q + 2'd1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 3'd1;
        2'b01:   cnt_q <= cnt_q - 3'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // issue/ready per slot, and drain depth = 1 + deepest older write to the same address
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      rd_enb[n] = slot_vld_q[n] & (drain_q[n] == 3'd0) & ~hold;
      rd_rdy[n] = ~slot_vld_q[n] | rd_enb[n];
      depth[n]  = 3'd0;
      for (int p = 0; p < 4; p++) begin
        if ((3'(p) < cnt_q) && (fifo_q[head_q + 2'(p)].adr == rq_adr[n]))
          depth[n] = 3'(p + 1);
      end
    end
  end

  // read slots: capture on accept, drain on pops, empty on issue
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (reset) begin
        slot_vld_q[n] <= 1'b0;
        slot_adr_q[n] <= '0;
        slot_tag_q[n] <= '0;
        drain_q[n]    <= 3'd0;
      end else if (rq_vld[n] && rd_rdy[n]) begin
        slot_vld_q[n] <= 1'b1;
        slot_adr_q[n] <= rq_adr[n];
        slot_tag_q[n] <= rq_tag[n];
        drain_q[n]    <= (pop && depth[n] != 3'd0) ? depth[n] - 3'd1 : depth[n];
      end else begin
        if (rd_enb[n]) slot_vld_q[n] <= 1'b0;
        if (pop && drain_q[n] != 3'd0) drain_q[n] <= drain_q[n] - 3'd1;
      end
    end
  end

  // response pipes shift every cycle regardless of hold
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (reset) begin
        for (int i = 0; i < RD_LAT; i++) begin
          pipe_vld_q[n][i] <= 1'b0;
          pipe_tag_q[n][i] <= '0;
        end
      end else begin
        pipe_vld_q[n][0] <= rd_enb[n];
        pipe_tag_q[n][0] <= slot_tag_q[n];
        for (int i = 1; i < RD_LAT; i++) begin
          pipe_vld_q[n][i] <= pipe_vld_q[n][i-1];
          pipe_tag_q[n][i] <= pipe_tag_q[n][i-1];
        end
      end
    end
  end

  assign rd_req_ready_0 = rd_rdy[0];
  assign rd_req_ready_1 = rd_rdy[1];
  assign rd_enb_0       = rd_enb[0];
  assign rd_enb_1       = rd_enb[1];
  assign rd_adr_0       = slot_adr_q[0];
  assign rd_adr_1       = slot_adr_q[1];
  assign rd_rsp_valid_0 = pipe_vld_q[0][RD_LAT-1];
  assign rd_rsp_tag_0   = pipe_tag_q[0][RD_LAT-1];
  assign rd_rsp_valid_1 = pipe_vld_q[1][RD_LAT-1];
  assign rd_rsp_tag_1   = pipe_tag_q[1][RD_LAT-1];

endmodule

// File: tb/tb_sdr_port_sequencer_2r1w_64.sv
// Purpose: directed vector bench for sdr_port_sequencer_2r1w_64 (RD_LAT=1).
// Latency: one vector per clock; inputs applied at negedge, outputs compared 1ns later.
// Backpressure: expected ready values are part of each vector.
module tb_sdr_port_sequencer_2r1w_64;

  logic        clk;
  logic        reset;
  logic        hold;
  logic        rd_req_valid_0, rd_req_ready_0;
  logic [0:5]  rd_req_adr_0;
  logic [3:0]  rd_req_tag_0;
  logic        rd_req_valid_1, rd_req_ready_1;
  logic [0:5]  rd_req_adr_1;
  logic [3:0]  rd_req_tag_1;
  logic        wr_req_valid, wr_req_ready;
  logic [0:5]  wr_req_adr;
  logic [31:0] wr_req_dat;
  logic        rd_enb_0, rd_enb_1, wr_enb_0;
  logic [0:5]  rd_adr_0, rd_adr_1, wr_adr_0;
  logic [31:0] wr_dat_0;
  logic        rd_rsp_valid_0, rd_rsp_valid_1;
  logic [3:0]  rd_rsp_tag_0, rd_rsp_tag_1;

  sdr_port_sequencer_2r1w_64 #(.DATA_W(32), .TAG_W(4), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .rd_req_valid_0(rd_req_valid_0), .rd_req_ready_0(rd_req_ready_0),
    .rd_req_adr_0(rd_req_adr_0), .rd_req_tag_0(rd_req_tag_0),
    .rd_req_valid_1(rd_req_valid_1), .rd_req_ready_1(rd_req_ready_1),
    .rd_req_adr_1(rd_req_adr_1), .rd_req_tag_1(rd_req_tag_1),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_req_adr(wr_req_adr), .wr_req_dat(wr_req_dat),
    .rd_enb_0(rd_enb_0), .rd_adr_0(rd_adr_0),
    .rd_enb_1(rd_enb_1), .rd_adr_1(rd_adr_1),
    .wr_enb_0(wr_enb_0), .wr_adr_0(wr_adr_0), .wr_dat_0(wr_dat_0),
    .rd_rsp_valid_0(rd_rsp_valid_0), .rd_rsp_tag_0(rd_rsp_tag_0),
    .rd_rsp_valid_1(rd_rsp_valid_1), .rd_rsp_tag_1(rd_rsp_tag_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one cycle: inputs driven this cycle and outputs expected this cycle
  typedef struct packed {
    logic        rst, hold;
    logic        rv0; logic [5:0] ra0; logic [3:0] rt0;
    logic        rv1; logic [5:0] ra1; logic [3:0] rt1;
    logic        wv;  logic [5:0] wa;  logic [31:0] wd;
    logic        chk, strict;
    logic        e_wrdy, e_rrdy0, e_rrdy1;
    logic        e_wen;  logic [5:0] e_wa; logic [31:0] e_wd;
    logic        e_ren0; logic [5:0] e_ra0;
    logic        e_ren1; logic [5:0] e_ra1;
    logic        e_rsp0; logic [3:0] e_tag0;
    logic        e_rsp1; logic [3:0] e_tag1;
  } vec_t;

  vec_t tbl[$];
  vec_t v;
  int   total  = 0;
  int   passed = 0;

  function automatic vec_t idle();
    vec_t r;
    r = '0;
    r.chk = 1'b1; r.e_wrdy = 1'b1; r.e_rrdy0 = 1'b1; r.e_rrdy1 = 1'b1;
    return r;
  endfunction

  // addresses/data/tags are compared only where their strobe is expected, or everywhere when strict
  task automatic check(input vec_t x, input string nm);
    logic ok;
    ok = (wr_req_ready === x.e_wrdy) && (rd_req_ready_0 === x.e_rrdy0) &&
         (rd_req_ready_1 === x.e_rrdy1) && (wr_enb_0 === x.e_wen) &&
         (rd_enb_0 === x.e_ren0) && (rd_enb_1 === x.e_ren1) &&
         (rd_rsp_valid_0 === x.e_rsp0) && (rd_rsp_valid_1 === x.e_rsp1);
    if ((x.e_wen || x.strict) && !((wr_adr_0 === x.e_wa) && (wr_dat_0 === x.e_wd))) ok = 1'b0;
    if ((x.e_ren0 || x.strict) && (rd_adr_0 !== x.e_ra0)) ok = 1'b0;
    if ((x.e_ren1 || x.strict) && (rd_adr_1 !== x.e_ra1)) ok = 1'b0;
    if ((x.e_rsp0 || x.strict) && (rd_rsp_tag_0 !== x.e_tag0)) ok = 1'b0;
    if ((x.e_rsp1 || x.strict) && (rd_rsp_tag_1 !== x.e_tag1)) ok = 1'b0;
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got rdy w%b r%b%b wen%b %h/%h ren0 %b %h ren1 %b %h rsp0 %b %h rsp1 %b %h; want rdy w%b r%b%b wen%b %h/%h ren0 %b %h ren1 %b %h rsp0 %b %h rsp1 %b %h",
                  nm, wr_req_ready, rd_req_ready_0, rd_req_ready_1, wr_enb_0, wr_adr_0, wr_dat_0,
                  rd_enb_0, rd_adr_0, rd_enb_1, rd_adr_1, rd_rsp_valid_0, rd_rsp_tag_0,
                  rd_rsp_valid_1, rd_rsp_tag_1,
                  x.e_wrdy, x.e_rrdy0, x.e_rrdy1, x.e_wen, x.e_wa, x.e_wd, x.e_ren0, x.e_ra0,
                  x.e_ren1, x.e_ra1, x.e_rsp0, x.e_tag0, x.e_rsp1, x.e_tag1);
  endtask

  task automatic run_vec(input vec_t x, input string nm);
    @(negedge clk);
    reset = x.rst; hold = x.hold;
    rd_req_valid_0 = x.rv0; rd_req_adr_0 = x.ra0; rd_req_tag_0 = x.rt0;
    rd_req_valid_1 = x.rv1; rd_req_adr_1 = x.ra1; rd_req_tag_1 = x.rt1;
    wr_req_valid = x.wv; wr_req_adr = x.wa; wr_req_dat = x.wd;
    #1;
    if (x.chk) check(x, nm);
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0;
    rd_req_valid_0 = 1'b0; rd_req_adr_0 = '0; rd_req_tag_0 = '0;
    rd_req_valid_1 = 1'b0; rd_req_adr_1 = '0; rd_req_tag_1 = '0;
    wr_req_valid = 1'b0; wr_req_adr = '0; wr_req_dat = '0;

    // reset, then reset-state check while read 0x05 tag 3 is presented
    v = idle(); v.rst = 1; v.chk = 0; tbl.push_back(v); tbl.push_back(v);
    v = idle(); v.strict = 1; v.rv0 = 1; v.ra0 = 6'h05; v.rt0 = 4'd3; tbl.push_back(v);
    v = idle(); v.e_ren0 = 1; v.e_ra0 = 6'h05; tbl.push_back(v);
    v = idle(); v.e_rsp0 = 1; v.e_tag0 = 4'd3; tbl.push_back(v);
    v = idle(); tbl.push_back(v);

    // writes 0x10,0x11,0x10 under hold, then read 0x10 on the releasing edge
    v = idle(); v.hold = 1; v.wv = 1; v.wa = 6'h10; v.wd = 32'hA1A1_0001; tbl.push_back(v);
    v = idle(); v.hold = 1; v.wv = 1; v.wa = 6'h11; v.wd = 32'hA1A1_0002; tbl.push_back(v);
    v = idle(); v.hold = 1; v.wv = 1; v.wa = 6'h10; v.wd = 32'hA1A1_0003; tbl.push_back(v);
    v = idle(); v.rv0 = 1; v.ra0 = 6'h10; v.rt0 = 4'd5;
    v.e_wen = 1; v.e_wa = 6'h10; v.e_wd = 32'hA1A1_0001; tbl.push_back(v);
    v = idle(); v.e_rrdy0 = 0; v.e_wen = 1; v.e_wa = 6'h11; v.e_wd = 32'hA1A1_0002; tbl.push_back(v);
    v = idle(); v.e_rrdy0 = 0; v.e_wen = 1; v.e_wa = 6'h10; v.e_wd = 32'hA1A1_0003; tbl.push_back(v);
    v = idle(); v.e_ren0 = 1; v.e_ra0 = 6'h10; tbl.push_back(v);
    v = idle(); v.e_rsp0 = 1; v.e_tag0 = 4'd5; tbl.push_back(v);

    // same-edge write and read to 0x20: read is younger-agnostic and not delayed
    v = idle(); v.wv = 1; v.wa = 6'h20; v.wd = 32'hB0B0_0020; v.rv1 = 1; v.ra1 = 6'h20; v.rt1 = 4'd9;
    tbl.push_back(v);
    v = idle(); v.e_wen = 1; v.e_wa = 6'h20; v.e_wd = 32'hB0B0_0020; v.e_ren1 = 1; v.e_ra1 = 6'h20;
    tbl.push_back(v);
    v = idle(); v.e_rsp1 = 1; v.e_tag1 = 4'd9; tbl.push_back(v);

    // hold blocks issue and ready; responses in flight still emerge under hold
    v = idle(); v.rv1 = 1; v.ra1 = 6'h07; v.rt1 = 4'd2; tbl.push_back(v);
    v = idle(); v.hold = 1; v.rv0 = 1; v.ra0 = 6'h08; v.rt0 = 4'd4; v.e_rrdy1 = 0; tbl.push_back(v);
    v = idle(); v.hold = 1; v.e_rrdy0 = 0; v.e_rrdy1 = 0; tbl.push_back(v);
    v = idle(); v.e_ren0 = 1; v.e_ra0 = 6'h08; v.e_ren1 = 1; v.e_ra1 = 6'h07; tbl.push_back(v);
    v = idle(); v.hold = 1; v.e_rsp0 = 1; v.e_tag0 = 4'd4; v.e_rsp1 = 1; v.e_tag1 = 4'd2;
    tbl.push_back(v);
    v = idle(); tbl.push_back(v);

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl[%0d]", i));

    // five writes under hold: fifth waits for space, then issues in order
    for (int k = 0; k < 11; k++) begin
      v = idle();
      v.hold = (k < 5);
      if (k < 7) begin
        v.wv = 1;
        v.wa = 6'(6'h30 + (k < 4 ? k : 4));
        v.wd = 32'hC000_0000 + 32'(k < 4 ? k : 4);
      end
      v.e_wrdy = !(k == 4 || k == 5);
      if (k >= 5 && k <= 9) begin
        v.e_wen = 1; v.e_wa = 6'(6'h30 + k - 5); v.e_wd = 32'hC000_0000 + 32'(k - 5);
      end
      run_vec(v, $sformatf("fifo_full[%0d]", k));
    end

    // continuous reads on both ports, one per cycle
    for (int k = 0; k < 18; k++) begin
      v = idle();
      if (k < 16) begin
        v.rv0 = 1; v.ra0 = 6'(k);      v.rt0 = 4'(k);
        v.rv1 = 1; v.ra1 = 6'(32 + k); v.rt1 = 4'(15 - k);
      end
      if (k >= 1 && k <= 16) begin
        v.e_ren0 = 1; v.e_ra0 = 6'(k - 1);
        v.e_ren1 = 1; v.e_ra1 = 6'(32 + k - 1);
      end
      if (k >= 2) begin
        v.e_rsp0 = 1; v.e_tag0 = 4'(k - 2);
        v.e_rsp1 = 1; v.e_tag1 = 4'(15 - (k - 2));
      end
      run_vec(v, $sformatf("stream[%0d]", k));
    end

    // reset with 3 queued writes, a stalled read and a read issuing
    v = idle(); v.hold = 1; v.wv = 1; v.wa = 6'h3A; v.wd = 32'hD000_003A;
    v.rv1 = 1; v.ra1 = 6'h01; v.rt1 = 4'd6; run_vec(v, "rst_load0");
    v = idle(); v.hold = 1; v.wv = 1; v.wa = 6'h3B; v.wd = 32'hD000_003B;
    v.rv0 = 1; v.ra0 = 6'h3A; v.rt0 = 4'd1; v.e_rrdy1 = 0; run_vec(v, "rst_load1");
    v = idle(); v.hold = 1; v.wv = 1; v.wa = 6'h3C; v.wd = 32'hD000_003C;
    v.e_rrdy0 = 0; v.e_rrdy1 = 0; run_vec(v, "rst_load2");
    v = idle(); v.rst = 1; v.e_rrdy0 = 0;
    v.e_wen = 1; v.e_wa = 6'h3A; v.e_wd = 32'hD000_003A; v.e_ren1 = 1; v.e_ra1 = 6'h01;
    run_vec(v, "rst_edge");
    for (int k = 0; k < 4; k++) begin
      v = idle(); v.strict = 1;
      run_vec(v, $sformatf("post_rst[%0d]", k));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
